// File: rtl/mdu_sequencer.sv
// -----------------------------------------------------------------------------
// mdu_sequencer
// Multiply/divide unit controller for the pipelined MIPS CPU.
//
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and runs each mul/div
// for a fixed number of cycles. The unit owns the HI/LO registers. While an
// operation is running it holds busy high, so the hazard unit stalls any later
// MDU instruction. An asserted cancel input aborts an operation that is in
// flight, and HI/LO keep the values they had before that operation started.
// This keeps HI/LO precise across exceptions and interrupts.
//
// Optional feature: define MDU_MADD_EN to enable MADD (7), MADDU (8) and
// MSUB (9). These accumulate into or subtract from {HI,LO} with MULT_CYCLES
// latency. When the macro is not defined, ops 7..15 are NOPs.
//
// Parameters
//   MULT_CYCLES  cycles busy stays high for MULT/MULTU (and MADD/MADDU/MSUB)
//   DIV_CYCLES   cycles busy stays high for DIV/DIVU
//
// Ports
//   clk     in   1   clock, rising edge
//   reset   in   1   synchronous, active-high reset
//   start   in   1   op valid this cycle
//   op      in   4   0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,
//                    7 MADD,8 MADDU,9 MSUB (7..9 only with MDU_MADD_EN)
//   a       in   32  rs operand
//   b       in   32  rt operand
//   cancel  in   1   flush: aborts the running op and any op started this cycle
//   busy    out  1   registered, high while a mul/div is in flight
//   done    out  1   registered one-cycle pulse when a result commits
//   hi      out  32  HI register
//   lo      out  32  LO register
// -----------------------------------------------------------------------------
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    // Decode the incoming op: does it run a multi-cycle operation, and how long
    logic               is_muldiv;
    logic [CNT_W-1:0]   op_cycles;

    always_comb begin
        is_muldiv = 1'b0;
        op_cycles = CNT_W'(MULT_CYCLES);
        case (op)
            OP_MULT, OP_MULTU: is_muldiv = 1'b1;
            OP_DIV, OP_DIVU: begin
                is_muldiv = 1'b1;
                op_cycles = CNT_W'(DIV_CYCLES);
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB: is_muldiv = 1'b1;
`endif
            default: is_muldiv = 1'b0;
        endcase
    end

    // Compute the result from the operands latched at accept time. Signed and
    // unsigned division share one divider. A signed divide works on magnitudes
    // and fixes the signs afterwards, so 0x8000_0000 / -1 wraps to
    // 0x8000_0000 with remainder 0 and needs no special case.
    logic [63:0] sprod, uprod;
    logic        div_signed;
    logic [31:0] a_mag, b_mag, dvd, dvs, quo, rem, quo_fix, rem_fix;
    logic [63:0] result;

    always_comb begin
        sprod      = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        uprod      = {32'd0, a_q} * {32'd0, b_q};
        div_signed = (op_q == OP_DIV);
        a_mag      = a_q[31] ? (32'd0 - a_q) : a_q;
        b_mag      = b_q[31] ? (32'd0 - b_q) : b_q;
        dvd        = div_signed ? a_mag : a_q;
        dvs        = div_signed ? b_mag : b_q;
        quo        = 32'd0;
        rem        = 32'd0;
        if (dvs != 32'd0) begin
            quo = dvd / dvs;
            rem = dvd % dvs;
        end
        quo_fix = quo;
        rem_fix = rem;
        if (div_signed) begin
            if (a_q[31] ^ b_q[31]) quo_fix = 32'd0 - quo;
            if (a_q[31])           rem_fix = 32'd0 - rem;
        end

        result = {hi_q, lo_q};
        case (op_q)
            OP_MULT:  result = sprod;
            OP_MULTU: result = uprod;
            OP_DIV, OP_DIVU: begin
                // Divide by zero does not trap: HI returns the dividend and LO is all ones
                if (b_q == 32'd0) result = {a_q, 32'hFFFF_FFFF};
                else              result = {rem_fix, quo_fix};
            end
`ifdef MDU_MADD_EN
            // Accumulate into HI/LO as they stand at commit time
            OP_MADD:  result = {hi_q, lo_q} + sprod;
            OP_MADDU: result = {hi_q, lo_q} + uprod;
            OP_MSUB:  result = {hi_q, lo_q} - sprod;
`endif
            default:  result = {hi_q, lo_q};
        endcase
    end

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start && !busy_q && !cancel) begin
                    if (is_muldiv) begin
                        state_d = ST_RUN;
                        cnt_d   = op_cycles;
                        op_d    = op;
                        a_d     = a;
                        b_d     = b;
                        busy_d  = 1'b1;
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            ST_RUN: begin
                // start is ignored here. cancel takes priority over a commit
                // on the same edge.
                if (cancel) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d        = ST_IDLE;
                    cnt_d          = '0;
                    busy_d         = 1'b0;
                    done_d         = 1'b1;
                    {hi_d, lo_d}   = result;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mdu_sequencer
// Directed and randomized checks of mdu_sequencer against a behavioural model.
// The model computes HI/LO with plain 64-bit integer arithmetic and expects
// busy/done to follow the stated latency.
// -----------------------------------------------------------------------------
module tb_mdu_sequencer;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        cancel;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    mdu_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference results computed straight from the arithmetic definitions
    function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] x,
                                               input logic [31:0] y, input logic [31:0] h,
                                               input logic [31:0] l);
        longint          sx = longint'($signed(x));
        longint          sy = longint'($signed(y));
        longint unsigned ux = {32'd0, x};
        longint unsigned uy = {32'd0, y};
        int              qi, ri;
        logic [63:0]     acc = {h, l};
        case (o)
            4'd1: return sx * sy;
            4'd2: return ux * uy;
            4'd3: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                qi = $signed(x) / $signed(y);
                ri = $signed(x) % $signed(y);
                return {ri, qi};
            end
            4'd4: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            4'd7: return acc + sx * sy;
            4'd8: return acc + ux * uy;
            4'd9: return acc - sx * sy;
            default: return acc;
        endcase
    endfunction

    function automatic bit runs(input logic [3:0] o);
`ifdef MDU_MADD_EN
        return (o >= 4'd1 && o <= 4'd4) || (o >= 4'd7 && o <= 4'd9);
`else
        return (o >= 4'd1 && o <= 4'd4);
`endif
    endfunction

    // Issue one op. cancel_at: 0 means no cancel, <0 means cancel in the
    // start cycle, and k>0 means cancel at the k-th edge after accept.
    // junk: drive random starts while busy, which must be ignored.
    task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int cancel_at, input bit junk);
        int          n;
        logic [63:0] exp;
        bit          acc;
        n   = (o == 4'd3 || o == 4'd4) ? DC : MC;
        acc = (cancel_at >= 0);
        exp = ref_result(o, x, y, m_hi, m_lo);
        start = 1'b1; op = o; a = x; b = y; cancel = (cancel_at < 0);
        step();
        start = 1'b0; op = 4'd0; cancel = 1'b0;
        if (runs(o) && acc) begin
            for (int k = 1; k <= n; k++) begin
                chk($sformatf("busy op%0d c%0d", o, k - 1), {busy, done}, 2'b10);
                if (junk) begin
                    start = 1'b1; op = 4'($urandom_range(1, 6));
                    a = $urandom; b = $urandom;
                end
                if (k == cancel_at) cancel = 1'b1;
                step();
                start = 1'b0; op = 4'd0; cancel = 1'b0;
                if (k == cancel_at) begin
                    chk($sformatf("cancel op%0d bd", o), {busy, done}, 2'b00);
                    chk($sformatf("cancel op%0d hilo", o), {hi, lo}, {m_hi, m_lo});
                    $display("op=%0d a=%h b=%h cancelled@%0d hi=%h lo=%h", o, x, y, k, hi, lo);
                    return;
                end
            end
            {m_hi, m_lo} = exp;
            chk($sformatf("done op%0d bd", o), {busy, done}, 2'b01);
        end else begin
            if (acc && o == 4'd5) m_hi = x;
            if (acc && o == 4'd6) m_lo = x;
            chk($sformatf("nop op%0d bd", o), {busy, done}, 2'b00);
        end
        chk($sformatf("hilo op%0d", o), {hi, lo}, {m_hi, m_lo});
        $display("op=%0d a=%h b=%h cancel=%0d hi=%h lo=%h", o, x, y, cancel_at, hi, lo);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [3:0]  ro;
        int          rc;
        reset = 1'b1; start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0; cancel = 1'b0;
        step(); step();
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        chk("reset state", {busy, done, hi, lo}, 66'd0);

        // Directed cases
        do_op(4'd1, 32'hFFFF_FFFE, 32'd3, 0, 0);
        chk("mult hilo const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        step();
        chk("done one-cycle", {busy, done}, 2'b00);
        do_op(4'd3, 32'hFFFF_FFF9, 32'd2, 0, 0);
        chk("div hilo const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(4'd4, 32'd7, 32'd0, 0, 0);
        chk("divu by zero const", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
        do_op(4'd3, 32'hFFFF_FFF9, 32'd0, 0, 0);
        do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        chk("div ovf const", {hi, lo}, 64'h0000_0000_8000_0000);
        do_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 0);
        do_op(4'd1, 32'd1234, 32'd5678, MC, 0);
        do_op(4'd3, 32'd1000, 32'd7, DC, 0);
        do_op(4'd5, 32'h0000_1234, 32'd0, 0, 0);
        do_op(4'd3, 32'd100, 32'hFFFF_FFF9, 0, 1);
        do_op(4'd1, 32'd9, 32'd9, 0, 1);

        // Reset in the middle of a DIV
        start = 1'b1; op = 4'd3; a = 32'd100; b = 32'd7;
        step();
        start = 1'b0; op = 4'd0;
        step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        chk("reset mid-op", {busy, done, hi, lo}, 66'd0);
        step();
        chk("reset no late done", {busy, done}, 2'b00);
        $display("reset during DIV busy=%0d hi=%h lo=%h", busy, hi, lo);

        // start together with cancel is dropped
        do_op(4'd1, 32'd3, 32'd4, -1, 0);
        step();
        chk("start+cancel no run", {busy, done}, 2'b00);
        do_op(4'd6, 32'hDEAD_BEEF, 32'd0, -1, 0);
        do_op(4'd6, 32'hFFFF_FFFF, 32'd0, 0, 0);
        do_op(4'd5, 32'd0, 32'd0, 0, 0);
        // MADDU (or NOP when MADD support is not built in)
        do_op(4'd8, 32'd1, 32'd1, 0, 0);
`ifdef MDU_MADD_EN
        chk("maddu const", {hi, lo}, 64'h0000_0001_0000_0000);
`else
        chk("op7 idle", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif
        do_op(4'd7, 32'd5, 32'd6, 0, 0);
        do_op(4'd12, 32'd5, 32'd6, 0, 0);

        // Randomized ops
        for (int i = 0; i < 60; i++) begin
            ro = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 6)) : 4'($urandom_range(0, 15));
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = $urandom_range(0, 50) - 25; rb = $urandom_range(0, 10) - 5; end
                default: ;
            endcase
            rc = 0;
            if ($urandom_range(0, 4) == 0) rc = $urandom_range(1, (ro == 4'd3 || ro == 4'd4) ? DC : MC);
            else if ($urandom_range(0, 9) == 0) rc = -1;
            do_op(ro, ra, rb, rc, bit'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
